multicycle_tracker: RTL and testbench
=====================================

# multicycle_tracker

Classifies each issued instruction as multiply, divide, load, store or single-cycle, and tracks occupancy of the shared mult/div unit and the memory port in the scoreboard issue stage. Each unit gets a parametrised latency counter. Issue stalls while a required unit is occupied. Completions are arbitrated onto a single writeback port with a valid/ready handshake that returns the destination tag. It extends the combinational multicycle/memory classifier with latency tracking, writeback arbitration and flush.

## Interface
Parameters:
- MULT_LAT, 4, multiply latency in cycles, ≥1
- DIV_LAT, 32, divide latency in cycles, ≥1
- MEM_LAT, 2, load/store latency in cycles, ≥1
- CNT_W, 6, counter width; must hold max(MULT_LAT, DIV_LAT, MEM_LAT)-1

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  instruction presented for issue
- issue_instr  in  32  instruction word
- issue_ready  out  1  instruction can be accepted this cycle
- is_multicycle  out  1  combinational: issue_instr is load, MULT or DIV
- is_mem  out  1  combinational: issue_instr is load or store
- md_busy  out  1  mult/div unit not IDLE
- mem_busy  out  1  memory port not IDLE
- wb_valid  out  1  completed result awaiting writeback
- wb_tag  out  5  destination register of the completing instruction
- wb_is_mem  out  1  1 = load completion, 0 = mult/div completion
- wb_ready  in  1  writeback consumed this cycle
- flush  in  1  synchronous squash of all in-flight work

## Operation
- Decode: opcode = instr[31:27], aluop = instr[6:2], rd = instr[26:22].
  - LOAD is opcode 01000.
  - STORE is opcode 00111.
  - MULT is opcode 00000 with aluop 00110.
  - DIV is opcode 00000 with aluop 00111.
  - Everything else is single-cycle.
- issue_ready:
  - 1 for single-cycle instructions.
  - For MULT/DIV: 1 iff the mult/div unit is IDLE at the start of the cycle.
  - For LOAD/STORE: 1 iff the memory port is IDLE at the start of the cycle.
  - 0 whenever flush=1.
- Accept means issue_valid & issue_ready & a multicycle/mem class. On accept, the target unit:
  - latches rd, plus a store flag (memory port only);
  - loads cnt = LAT-1;
  - enters COUNT.
- Per-unit FSM, states IDLE, COUNT, DONE:
  - COUNT with cnt≠0: decrement.
  - COUNT with cnt==0: go to DONE. A store goes to IDLE instead and produces no writeback.
  - DONE: request writeback. Go to IDLE on grant & wb_ready; otherwise hold.
- Writeback arbitration: the memory port has priority over mult/div.
  - wb_valid = either unit in DONE.
  - wb_tag and wb_is_mem come from the granted unit.
  - The loser holds in DONE.
- A unit freed at an edge is IDLE, and can accept, in the next cycle only. No same-cycle reuse.
- flush=1: both units go to IDLE at the edge. wb_valid is forced to 0 that cycle, and any issue that cycle is ignored.

## Timing
- Reset (reset_n=0, asynchronous):
  - both units IDLE, cnt=0, tags=0;
  - md_busy=0, mem_busy=0;
  - wb_valid=0, wb_tag=0, wb_is_mem=0;
  - issue_ready=1 immediately.
- Accept at cycle T → unit in COUNT from T+1 → wb_valid first asserted in cycle T+LAT+1 (DONE state), provided it wins arbitration.
- Store accepted at T: mem_busy=1 in T+1..T+MEM_LAT, 0 in T+MEM_LAT+1.
- Load/mult completion with wb_ready=1 held: busy in T+1..T+LAT+1, IDLE at T+LAT+2.
- wb_valid/wb_tag stay stable while wb_ready=0.
- Both units reaching DONE in the same cycle: load written back first, mult/div one cycle later (given wb_ready=1).
- Reset deassertion mid-operation is not special. Reset assertion aborts everything with no writeback.

## Test plan
- Reset, then MULT rd=3 (0x00C00018) issued at T, wb_ready=1:
  - md_busy=1 in T+1..T+5;
  - wb_valid=1, wb_tag=3, wb_is_mem=0 in T+5;
  - md_busy=0 at T+6.
- DIV rd=4 (0x0100001C) at T, then MULT at T+1:
  - issue_ready=0 for the MULT until T+34;
  - the MULT is accepted at T+34.
- LOAD rd=5 (0x41400000) and MULT rd=3 timed so both reach DONE together:
  - wb_tag=5, wb_is_mem=1 first;
  - wb_tag=3 on the next cycle.
- STORE (0x38000000) at T:
  - mem_busy=1 in T+1..T+2;
  - wb_valid stays 0 throughout;
  - LOAD accepted at T+3.
- LOAD issued, wb_ready=0 for 4 cycles:
  - wb_valid=1 and wb_tag=5 held stable;
  - a second LOAD is blocked (issue_ready=0) until 1 cycle after wb_ready=1.
- DIV in flight, flush=1 at cycle 10:
  - md_busy=0 and wb_valid=0 from cycle 11;
  - an issue in cycle 10 is ignored.
- Separately, reset_n pulsed low mid-COUNT: all outputs go to reset values immediately.

Source files
------------

// File: rtl/multicycle_tracker.sv
// Issue-stage tracker for the shared mult/div unit and the memory port: decodes the
// instruction class, stalls issue on busy units and arbitrates completions onto one writeback port.
module multicycle_tracker #(
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned DIV_LAT  = 32,
    parameter int unsigned MEM_LAT  = 2,
    parameter int unsigned CNT_W    = 6
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        issue_valid,
    input  logic [31:0] issue_instr,
    output logic        issue_ready,
    output logic        is_multicycle,
    output logic        is_mem,
    output logic        md_busy,
    output logic        mem_busy,
    output logic        wb_valid,
    output logic [4:0]  wb_tag,
    output logic        wb_is_mem,
    input  logic        wb_ready,
    input  logic        flush
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } unit_state_t;

    localparam logic [CNT_W-1:0] MULT_INIT = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_INIT  = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] MEM_INIT  = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [4:0]  opcode_s;
    logic [4:0]  aluop_s;
    logic [4:0]  rd_s;
    logic        is_load_s;
    logic        is_store_s;
    logic        is_mult_s;
    logic        is_div_s;
    logic        issue_ready_s;
    logic        md_accept_s;
    logic        mem_accept_s;
    logic        md_grant_s;
    logic        mem_grant_s;
    logic        wb_valid_s;
    logic [4:0]  wb_tag_s;
    logic        wb_is_mem_s;
    logic        unused_instr_s;

    unit_state_t      md_state_r;
    logic [CNT_W-1:0] md_cnt_r;
    logic [4:0]       md_tag_r;
    unit_state_t      mem_state_r;
    logic [CNT_W-1:0] mem_cnt_r;
    logic [4:0]       mem_tag_r;
    logic             mem_store_r;

    assign opcode_s       = issue_instr[31:27];
    assign rd_s           = issue_instr[26:22];
    assign aluop_s        = issue_instr[6:2];
    assign unused_instr_s = ^{issue_instr[21:7], issue_instr[1:0]};

    assign is_load_s  = (opcode_s == 5'b01000);
    assign is_store_s = (opcode_s == 5'b00111);
    assign is_mult_s  = (opcode_s == 5'b00000) && (aluop_s == 5'b00110);
    assign is_div_s   = (opcode_s == 5'b00000) && (aluop_s == 5'b00111);

    assign is_multicycle = is_load_s | is_mult_s | is_div_s;
    assign is_mem        = is_load_s | is_store_s;

    // Issue readiness: a class only waits on its own unit; flush blocks everything.
    always_comb begin
        issue_ready_s = 1'b1;
        if (flush) begin
            issue_ready_s = 1'b0;
        end else if (is_mult_s || is_div_s) begin
            issue_ready_s = (md_state_r == ST_IDLE);
        end else if (is_load_s || is_store_s) begin
            issue_ready_s = (mem_state_r == ST_IDLE);
        end else begin
            issue_ready_s = 1'b1;
        end
    end

    assign issue_ready  = issue_ready_s;
    assign md_accept_s  = issue_valid & issue_ready_s & (is_mult_s | is_div_s);
    assign mem_accept_s = issue_valid & issue_ready_s & (is_load_s | is_store_s);

    // Writeback arbitration: memory port wins; flush suppresses any grant.
    always_comb begin
        mem_grant_s = 1'b0;
        md_grant_s  = 1'b0;
        wb_valid_s  = 1'b0;
        wb_tag_s    = 5'd0;
        wb_is_mem_s = 1'b0;
        if (flush) begin
            wb_valid_s = 1'b0;
        end else if (mem_state_r == ST_DONE) begin
            mem_grant_s = 1'b1;
            wb_valid_s  = 1'b1;
            wb_tag_s    = mem_tag_r;
            wb_is_mem_s = 1'b1;
        end else if (md_state_r == ST_DONE) begin
            md_grant_s  = 1'b1;
            wb_valid_s  = 1'b1;
            wb_tag_s    = md_tag_r;
            wb_is_mem_s = 1'b0;
        end else begin
            wb_valid_s = 1'b0;
        end
    end

    assign wb_valid  = wb_valid_s;
    assign wb_tag    = wb_tag_s;
    assign wb_is_mem = wb_is_mem_s;
    assign md_busy   = (md_state_r != ST_IDLE);
    assign mem_busy  = (mem_state_r != ST_IDLE);

    // Mult/div unit FSM: latency countdown followed by a writeback request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            md_state_r <= ST_IDLE;
            md_cnt_r   <= CNT_ZERO;
            md_tag_r   <= 5'd0;
        end else if (flush) begin
            md_state_r <= ST_IDLE;
            md_cnt_r   <= CNT_ZERO;
        end else begin
            case (md_state_r)
                ST_IDLE: begin
                    if (md_accept_s) begin
                        md_state_r <= ST_COUNT;
                        md_cnt_r   <= is_div_s ? DIV_INIT : MULT_INIT;
                        md_tag_r   <= rd_s;
                    end
                end
                ST_COUNT: begin
                    if (md_cnt_r == CNT_ZERO) begin
                        md_state_r <= ST_DONE;
                    end else begin
                        md_cnt_r <= md_cnt_r - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (md_grant_s && wb_ready) begin
                        md_state_r <= ST_IDLE;
                    end
                end
                default: begin
                    md_state_r <= ST_IDLE;
                    md_cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    // Memory port FSM: stores retire silently when the countdown expires.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_state_r <= ST_IDLE;
            mem_cnt_r   <= CNT_ZERO;
            mem_tag_r   <= 5'd0;
            mem_store_r <= 1'b0;
        end else if (flush) begin
            mem_state_r <= ST_IDLE;
            mem_cnt_r   <= CNT_ZERO;
        end else begin
            case (mem_state_r)
                ST_IDLE: begin
                    if (mem_accept_s) begin
                        mem_state_r <= ST_COUNT;
                        mem_cnt_r   <= MEM_INIT;
                        mem_tag_r   <= rd_s;
                        mem_store_r <= is_store_s;
                    end
                end
                ST_COUNT: begin
                    if (mem_cnt_r == CNT_ZERO) begin
                        mem_state_r <= mem_store_r ? ST_IDLE : ST_DONE;
                    end else begin
                        mem_cnt_r <= mem_cnt_r - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (mem_grant_s && wb_ready) begin
                        mem_state_r <= ST_IDLE;
                    end
                end
                default: begin
                    mem_state_r <= ST_IDLE;
                    mem_cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_tracker.sv
// Bench for multicycle_tracker: decode vector table, scoreboarded writebacks and
// hand-written latency, arbitration, stall, flush and reset sequences.
module tb_multicycle_tracker;

    localparam logic [31:0] I_MULT  = 32'h00C00018;
    localparam logic [31:0] I_DIV   = 32'h0100001C;
    localparam logic [31:0] I_LOAD  = 32'h41400000;
    localparam logic [31:0] I_LOAD6 = 32'h41800000;
    localparam logic [31:0] I_STORE = 32'h38000000;

    logic        clock;
    logic        reset_n;
    logic        issue_valid;
    logic [31:0] issue_instr;
    logic        issue_ready;
    logic        is_multicycle;
    logic        is_mem;
    logic        md_busy;
    logic        mem_busy;
    logic        wb_valid;
    logic [4:0]  wb_tag;
    logic        wb_is_mem;
    logic        wb_ready;
    logic        flush;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [4:0] tag;
        logic       is_mem;
    } wb_exp_t;
    wb_exp_t sb_q[$];

    typedef struct {
        logic [31:0] instr;
        logic        fl;
        logic        exp_mc;
        logic        exp_mem;
        logic        exp_ready;
    } dec_vec_t;
    dec_vec_t vecs[9];

    multicycle_tracker #(.MULT_LAT(4), .DIV_LAT(32), .MEM_LAT(2), .CNT_W(6)) dut (
        .clock(clock), .reset_n(reset_n), .issue_valid(issue_valid), .issue_instr(issue_instr),
        .issue_ready(issue_ready), .is_multicycle(is_multicycle), .is_mem(is_mem),
        .md_busy(md_busy), .mem_busy(mem_busy), .wb_valid(wb_valid), .wb_tag(wb_tag),
        .wb_is_mem(wb_is_mem), .wb_ready(wb_ready), .flush(flush)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Scoreboard: every completed handshake pops the next expected writeback.
    always @(negedge clock) begin
        if (reset_n && wb_valid && wb_ready) begin
            if (sb_q.size() == 0) begin
                chk("wb_unexpected", 32'd1, 32'd0);
            end else begin
                chk("wb_tag_sb", 32'(wb_tag), 32'(sb_q[0].tag));
                chk("wb_is_mem_sb", 32'(wb_is_mem), 32'(sb_q[0].is_mem));
                void'(sb_q.pop_front());
            end
        end
    end

    task automatic cyc(input logic v, input logic [31:0] ins, input logic wbr, input logic fl);
        @(posedge clock);
        #1;
        issue_valid = v;
        issue_instr = ins;
        wb_ready    = wbr;
        flush       = fl;
        #1;
    endtask

    task automatic push_exp(input logic [4:0] tag, input logic m);
        wb_exp_t e;
        e.tag    = tag;
        e.is_mem = m;
        sb_q.push_back(e);
    endtask

    initial begin
        reset_n = 1'b0; issue_valid = 1'b0; issue_instr = 32'd0; wb_ready = 1'b1; flush = 1'b0;

        vecs[0] = '{I_MULT,        1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{I_DIV,         1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{I_LOAD,        1'b0, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{I_STORE,       1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{32'h00000014,  1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'h48000018,  1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{32'hFFFFFFFF,  1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{32'h0000001C,  1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{32'h12345678,  1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge clock);
        #2;
        chk("rst_issue_ready", 32'(issue_ready), 32'd1);
        chk("rst_md_busy", 32'(md_busy), 32'd0);
        chk("rst_mem_busy", 32'(mem_busy), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_tag", 32'(wb_tag), 32'd0);
        chk("rst_wb_is_mem", 32'(wb_is_mem), 32'd0);
        reset_n = 1'b1;

        // Decode table (no issue_valid, so nothing is accepted)
        for (int i = 0; i < 9; i++) begin
            cyc(1'b0, vecs[i].instr, 1'b1, vecs[i].fl);
            chk($sformatf("dec%0d_multicycle", i), 32'(is_multicycle), 32'(vecs[i].exp_mc));
            chk($sformatf("dec%0d_mem", i), 32'(is_mem), 32'(vecs[i].exp_mem));
            chk($sformatf("dec%0d_ready", i), 32'(issue_ready), 32'(vecs[i].exp_ready));
        end

        // MULT latency
        cyc(1'b1, I_MULT, 1'b1, 1'b0);
        chk("mult_ready", 32'(issue_ready), 32'd1);
        push_exp(5'd3, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            cyc(1'b0, 32'd0, 1'b1, 1'b0);
            chk($sformatf("mult_busy_t%0d", k), 32'(md_busy), 32'(k <= 5));
            chk($sformatf("mult_wbv_t%0d", k), 32'(wb_valid), 32'(k == 5));
            if (k == 5) begin
                chk("mult_wb_tag", 32'(wb_tag), 32'd3);
                chk("mult_wb_is_mem", 32'(wb_is_mem), 32'd0);
            end
        end

        // DIV blocks a following MULT until T+34
        cyc(1'b1, I_DIV, 1'b1, 1'b0);
        push_exp(5'd4, 1'b0);
        push_exp(5'd3, 1'b0);
        for (int t = 1; t <= 34; t++) begin
            cyc(1'b1, I_MULT, 1'b1, 1'b0);
            chk($sformatf("div_stall_t%0d", t), 32'(issue_ready), 32'(t == 34));
            if (t == 33) chk("div_wb_tag", 32'(wb_tag), 32'd4);
        end
        for (int t = 35; t <= 40; t++) begin
            cyc(1'b0, 32'd0, 1'b1, 1'b0);
            chk($sformatf("div_mult_wbv_t%0d", t), 32'(wb_valid), 32'(t == 39));
        end
        chk("div_mult_idle", 32'(md_busy), 32'd0);

        // LOAD and MULT finishing together
        cyc(1'b1, I_MULT, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        cyc(1'b1, I_LOAD, 1'b1, 1'b0);
        chk("arb_load_ready", 32'(issue_ready), 32'd1);
        push_exp(5'd5, 1'b1);
        push_exp(5'd3, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        chk("arb_first_tag", 32'(wb_tag), 32'd5);
        chk("arb_first_mem", 32'(wb_is_mem), 32'd1);
        chk("arb_md_waiting", 32'(md_busy), 32'd1);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        chk("arb_second_valid", 32'(wb_valid), 32'd1);
        chk("arb_second_tag", 32'(wb_tag), 32'd3);
        chk("arb_mem_free", 32'(mem_busy), 32'd0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        chk("arb_drained", 32'(wb_valid), 32'd0);

        // STORE: no writeback, port free at T+3
        cyc(1'b1, I_STORE, 1'b1, 1'b0);
        for (int t = 1; t <= 2; t++) begin
            cyc(1'b0, 32'd0, 1'b1, 1'b0);
            chk($sformatf("st_busy_t%0d", t), 32'(mem_busy), 32'd1);
            chk($sformatf("st_wbv_t%0d", t), 32'(wb_valid), 32'd0);
        end
        cyc(1'b1, I_LOAD, 1'b1, 1'b0);
        chk("st_free", 32'(mem_busy), 32'd0);
        chk("st_wbv_t3", 32'(wb_valid), 32'd0);
        chk("st_load_ready", 32'(issue_ready), 32'd1);
        push_exp(5'd5, 1'b1);
        for (int j = 1; j <= 4; j++) begin
            cyc(1'b0, 32'd0, 1'b1, 1'b0);
            chk($sformatf("st_load_wbv_%0d", j), 32'(wb_valid), 32'(j == 3));
        end

        // Writeback back-pressure
        cyc(1'b1, I_LOAD, 1'b0, 1'b0);
        push_exp(5'd5, 1'b1);
        cyc(1'b0, 32'd0, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0);
        for (int j = 3; j <= 7; j++) begin
            cyc(1'b1, I_LOAD6, (j == 7), 1'b0);
            chk($sformatf("bp_wbv_%0d", j), 32'(wb_valid), 32'd1);
            chk($sformatf("bp_tag_%0d", j), 32'(wb_tag), 32'd5);
            chk($sformatf("bp_block_%0d", j), 32'(issue_ready), 32'd0);
        end
        cyc(1'b1, I_LOAD6, 1'b1, 1'b0);
        chk("bp_second_ready", 32'(issue_ready), 32'd1);
        push_exp(5'd6, 1'b1);
        for (int j = 9; j <= 12; j++) begin
            cyc(1'b0, 32'd0, 1'b1, 1'b0);
            chk($sformatf("bp2_wbv_%0d", j), 32'(wb_valid), 32'(j == 11));
        end
        chk("bp2_idle", 32'(mem_busy), 32'd0);

        // Flush of an in-flight DIV, with an ignored issue
        cyc(1'b1, I_DIV, 1'b1, 1'b0);
        for (int j = 1; j <= 4; j++) begin
            cyc(1'b0, 32'd0, 1'b1, 1'b0);
            chk($sformatf("fl_busy_%0d", j), 32'(md_busy), 32'd1);
        end
        cyc(1'b1, I_LOAD, 1'b1, 1'b1);
        chk("fl_ready", 32'(issue_ready), 32'd0);
        chk("fl_wbv", 32'(wb_valid), 32'd0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        chk("fl_md_idle", 32'(md_busy), 32'd0);
        chk("fl_mem_idle", 32'(mem_busy), 32'd0);
        chk("fl_wbv_after", 32'(wb_valid), 32'd0);

        // Flush while a result waits in DONE
        cyc(1'b1, I_MULT, 1'b0, 1'b0);
        for (int j = 1; j <= 5; j++) cyc(1'b0, 32'd0, 1'b0, 1'b0);
        chk("fld_wbv", 32'(wb_valid), 32'd1);
        cyc(1'b0, 32'd0, 1'b1, 1'b1);
        chk("fld_wbv_forced", 32'(wb_valid), 32'd0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        chk("fld_idle", 32'(md_busy), 32'd0);
        chk("fld_wbv_after", 32'(wb_valid), 32'd0);

        // Asynchronous reset mid-COUNT
        cyc(1'b1, I_MULT, 1'b1, 1'b0);
        cyc(1'b1, I_LOAD, 1'b1, 1'b0);
        cyc(1'b0, I_MULT, 1'b1, 1'b0);
        chk("ar_md_busy_pre", 32'(md_busy), 32'd1);
        chk("ar_mem_busy_pre", 32'(mem_busy), 32'd1);
        chk("ar_ready_pre", 32'(issue_ready), 32'd0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("ar_md_busy", 32'(md_busy), 32'd0);
        chk("ar_mem_busy", 32'(mem_busy), 32'd0);
        chk("ar_wbv", 32'(wb_valid), 32'd0);
        chk("ar_tag", 32'(wb_tag), 32'd0);
        chk("ar_is_mem", 32'(wb_is_mem), 32'd0);
        chk("ar_ready", 32'(issue_ready), 32'd1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            cyc(1'b0, 32'd0, 1'b1, 1'b0);
            chk($sformatf("ar_no_wb_%0d", j), 32'(wb_valid), 32'd0);
        end

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
